// File: rtl/sw_debounce_ctrl.sv
// Avalon-MM switch/key controller: 2-FF sync, per-bit debounce with a programmable period,
// edge capture with W1C clear and a maskable, registered level IRQ.
module sw_debounce_ctrl #(
  parameter int unsigned N_SW       = 4,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned DEF_PERIOD = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_SW-1:0]   in_port,
  output logic              irq
);

  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrPeriod  = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrCapture = 3'd3;
  localparam logic [2:0] AddrRiseEn  = 3'd4;
  localparam logic [2:0] AddrFallEn  = 3'd5;

  logic [N_SW-1:0]            s1_q, s2_q;
  logic [N_SW-1:0]            stable_q, stable_d;
  logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]           period_q, period_d;
  logic [N_SW-1:0]            mask_q, mask_d;
  logic [N_SW-1:0]            capture_q, capture_d;
  logic [N_SW-1:0]            rise_en_q, rise_en_d;
  logic [N_SW-1:0]            fall_en_q, fall_en_d;
  logic [31:0]                readdata_q, readdata_d;
  logic                       irq_q, irq_d;

  logic                       wr_en;
  logic [N_SW-1:0]            accept;
  logic [N_SW-1:0]            w1c;
  logic                       unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Per-bit debounce: count while the synchronised level differs from the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == period_q) begin
        accept[i]   = 1'b1;
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    period_d  = period_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (address)
        AddrPeriod:  period_d  = writedata[CNT_W-1:0];
        AddrMask:    mask_d    = writedata[N_SW-1:0];
        AddrCapture: w1c       = writedata[N_SW-1:0];
        AddrRiseEn:  rise_en_d = writedata[N_SW-1:0];
        AddrFallEn:  fall_en_d = writedata[N_SW-1:0];
        default:     ;
      endcase
    end
  end

  // A newly accepted edge wins over a simultaneous software clear of the same bit.
  always_comb begin
    capture_d = (capture_q & ~w1c)
              | (accept & s2_q & rise_en_q)
              | (accept & ~s2_q & fall_en_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[N_SW-1:0]  = stable_q;
      AddrPeriod:  readdata_d[CNT_W-1:0] = period_q;
      AddrMask:    readdata_d[N_SW-1:0]  = mask_q;
      AddrCapture: readdata_d[N_SW-1:0]  = capture_q;
      AddrRiseEn:  readdata_d[N_SW-1:0]  = rise_en_q;
      AddrFallEn:  readdata_d[N_SW-1:0]  = fall_en_q;
      default:     readdata_d            = '0;
    endcase
  end

  assign irq_d = |(capture_q & mask_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      period_q   <= CNT_W'(DEF_PERIOD);
      mask_q     <= '0;
      capture_q  <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Directed bench for sw_debounce_ctrl: register table plus hand-timed debounce/capture sequences.
module tb_sw_debounce_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] rd;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  sw_debounce_ctrl #(
    .N_SW       (4),
    .CNT_W      (8),
    .DEF_PERIOD (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    step();
    rd = readdata;
    check(name, rd, exp);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{3'd1, 1'b0, 32'h0,        32'h3};
    vecs[2]  = '{3'd2, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{3'd3, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{3'd4, 1'b0, 32'h0,        32'hF};
    vecs[5]  = '{3'd5, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{3'd6, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{3'd7, 1'b0, 32'h0,        32'h0};
    vecs[8]  = '{3'd2, 1'b1, 32'hFFFFFFFF, 32'hF};
    vecs[9]  = '{3'd1, 1'b1, 32'h000001FF, 32'hFF};
    vecs[10] = '{3'd0, 1'b1, 32'hF,        32'h0};
    vecs[11] = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{3'd2, 1'b1, 32'h0,        32'h0};
    vecs[13] = '{3'd1, 1'b1, 32'h3,        32'h3};
    vecs[14] = '{3'd4, 1'b1, 32'h5,        32'h5};
    vecs[15] = '{3'd4, 1'b1, 32'hFFFFFFFF, 32'hF};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'h0;
    repeat (3) step();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Rising edge on bit0: stable after 6 clocks, visible on readdata one later.
    address = 3'd0;
    in_port = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("rise_lat_k6", readdata, 32'h0);
      if (k == 7) check("rise_lat_k7", readdata, 32'h1);
    end
    read_check("cap_after_rise", 3'd3, 32'h1);
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(3'd2, 32'h1);
    check("irq_mask_edge", {31'h0, irq}, 32'h0);
    step();
    check("irq_unmasked", {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h1);
    check("irq_w1c_edge", {31'h0, irq}, 32'h1);
    step();
    check("irq_after_w1c", {31'h0, irq}, 32'h0);

    // Short pulse on bit1 is filtered out.
    in_port = 4'b0011;
    step();
    step();
    in_port = 4'b0001;
    repeat (10) step();
    read_check("pulse_data", 3'd0, 32'h1);
    read_check("pulse_capture", 3'd3, 32'h0);

    // 1-0-1 glitch restarts the count; accept 6 clocks after the last change.
    address = 3'd0;
    in_port = 4'b0011;
    step();
    step();
    in_port = 4'b0001;
    step();
    in_port = 4'b0011;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("glitch_lat_k6", readdata, 32'h1);
      if (k == 7) check("glitch_lat_k7", readdata, 32'h3);
    end
    read_check("glitch_capture", 3'd3, 32'h2);
    bus_write(3'd3, 32'h2);
    read_check("glitch_cap_clr", 3'd3, 32'h0);

    // Falling-only capture on bit2.
    bus_write(3'd5, 32'h4);
    bus_write(3'd4, 32'h0);
    in_port = 4'b0111;
    repeat (10) step();
    read_check("fall_only_rise_cap", 3'd3, 32'h0);
    read_check("fall_only_rise_data", 3'd0, 32'h7);
    in_port = 4'b0011;
    repeat (10) step();
    read_check("fall_only_fall_cap", 3'd3, 32'h4);
    bus_write(3'd3, 32'h4);

    // W1C in the same cycle as an accepted edge: set wins on that bit only.
    bus_write(3'd4, 32'hF);
    bus_write(3'd5, 32'hF);
    in_port = 4'b0001;
    repeat (10) step();
    read_check("race_pre_cap", 3'd3, 32'h2);
    in_port = 4'b0000;
    repeat (5) step();
    bus_write(3'd3, 32'h3);
    read_check("race_cap", 3'd3, 32'h1);
    check("race_irq", {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h1);
    read_check("race_cap_clr", 3'd3, 32'h0);

    // PERIOD=0 bypass: stable 3 clocks after change.
    bus_write(3'd1, 32'h0);
    address = 3'd0;
    in_port = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check("bypass_k3", readdata, 32'h0);
      if (k == 4) check("bypass_k4", readdata, 32'h5);
    end

    // Reset in the middle of a count discards it.
    bus_write(3'd2, 32'hF);
    bus_write(3'd1, 32'h3);
    in_port = 4'b1111;
    repeat (4) step();
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    step();
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    in_port = 4'b0000;
    step();
    reset_n = 1'b1;
    repeat (10) step();
    read_check("post_period", 3'd1, 32'h3);
    read_check("post_mask", 3'd2, 32'h0);
    read_check("post_capture", 3'd3, 32'h0);
    read_check("post_rise_en", 3'd4, 32'hF);
    read_check("post_fall_en", 3'd5, 32'h0);
    read_check("post_data", 3'd0, 32'h0);
    check("post_irq", {31'h0, irq}, 32'h0);
    in_port = 4'b1000;
    repeat (10) step();
    read_check("post_new_data", 3'd0, 32'h8);
    read_check("post_new_cap", 3'd3, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
